// File: rtl/falling_char_tracker.sv
// Slot table for a falling-character typing game: periodic spawns, per-tick falling,
// key matching against on-screen characters, and registered score/miss/game-over.
module falling_char_tracker #(
  parameter int         SLOTS        = 8,
  parameter logic [8:0] X_LIMIT      = 9'd470,
  parameter int         SPAWN_PERIOD = 60,
  parameter int         MISS_MAX     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [7:0]  gen_ch,
  input  logic [2:0]  gen_speed,
  input  logic [8:0]  gen_x,
  input  logic [9:0]  gen_y,
  input  logic        key_valid,
  input  logic [7:0]  key_ch,
  input  logic [2:0]  rd_idx,
  output logic        rd_active,
  output logic [7:0]  rd_ch,
  output logic [8:0]  rd_x,
  output logic [9:0]  rd_y,
  output logic [15:0] score,
  output logic [7:0]  miss,
  output logic        game_over
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

  logic       active_q [SLOTS];
  logic [7:0] ch_q     [SLOTS];
  logic [2:0] speed_q  [SLOTS];
  logic [8:0] x_q      [SLOTS];
  logic [9:0] y_q      [SLOTS];

  logic       active_n [SLOTS];
  logic [7:0] ch_n     [SLOTS];
  logic [2:0] speed_n  [SLOTS];
  logic [8:0] x_n      [SLOTS];
  logic [9:0] y_n      [SLOTS];

  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [15:0]      score_q, score_n;
  logic [7:0]       miss_q, miss_n;
  logic             game_over_q, game_over_n;

  logic       run, wrap;
  logic       hit_found, free_found, do_key, do_spawn;
  int         hit_idx, free_idx;
  logic [8:0] miss_count, miss_sum;

  // Key match and free-slot search both look at start-of-cycle state, so a slot
  // freed this cycle is never the spawn target.
  always_comb begin
    run        = tick && !game_over_q;
    wrap       = run && (cnt_q == CNT_LAST);
    hit_found  = 1'b0;
    hit_idx    = 0;
    free_found = 1'b0;
    free_idx   = 0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!hit_found && active_q[i] && (ch_q[i] == key_ch)) begin
        hit_found = 1'b1;
        hit_idx   = i;
      end
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = i;
      end
    end
    do_key   = key_valid && !game_over_q && hit_found;
    do_spawn = wrap && free_found;
  end

  // A hit takes priority over movement/miss for the same slot.
  always_comb begin
    active_n   = active_q;
    ch_n       = ch_q;
    speed_n    = speed_q;
    x_n        = x_q;
    y_n        = y_q;
    miss_count = 9'd0;
    for (int i = 0; i < SLOTS; i++) begin
      if (do_key && (i == hit_idx)) begin
        active_n[i] = 1'b0;
      end else if (run && active_q[i]) begin
        if (({1'b0, x_q[i]} + {7'd0, speed_q[i]}) >= {1'b0, X_LIMIT}) begin
          active_n[i] = 1'b0;
          miss_count  = miss_count + 9'd1;
        end else begin
          x_n[i] = x_q[i] + {6'd0, speed_q[i]};
        end
      end
      if (do_spawn && (i == free_idx)) begin
        active_n[i] = 1'b1;
        ch_n[i]     = gen_ch;
        speed_n[i]  = gen_speed;
        x_n[i]      = gen_x;
        y_n[i]      = gen_y;
      end
    end
  end

  always_comb begin
    cnt_n = cnt_q;
    if (run) begin
      cnt_n = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    score_n     = (do_key && (score_q != 16'hFFFF)) ? score_q + 16'd1 : score_q;
    miss_sum    = {1'b0, miss_q} + miss_count;
    miss_n      = (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
    game_over_n = game_over_q || (32'(miss_q) >= MISS_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        active_q[i] <= 1'b0;
        ch_q[i]     <= '0;
        speed_q[i]  <= '0;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
      end
      cnt_q       <= '0;
      score_q     <= '0;
      miss_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      active_q    <= active_n;
      ch_q        <= ch_n;
      speed_q     <= speed_n;
      x_q         <= x_n;
      y_q         <= y_n;
      cnt_q       <= cnt_n;
      score_q     <= score_n;
      miss_q      <= miss_n;
      game_over_q <= game_over_n;
    end
  end

  // Indices beyond the slot table read back as an empty slot.
  always_comb begin
    rd_active = 1'b0;
    rd_ch     = '0;
    rd_x      = '0;
    rd_y      = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (32'(rd_idx) == i) begin
        rd_active = active_q[i];
        rd_ch     = ch_q[i];
        rd_x      = x_q[i];
        rd_y      = y_q[i];
      end
    end
  end

  assign score     = score_q;
  assign miss      = miss_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_falling_char_tracker.sv
// Scoreboard bench for falling_char_tracker: directed scenarios push expected values,
// a monitor process pops them, selects the slot and compares against the DUT.
module tb_falling_char_tracker;

  localparam int K_ACT = 0, K_CH = 1, K_X = 2, K_Y = 3, K_SCORE = 4, K_MISS = 5, K_GO = 6;

  typedef struct {
    string name;
    int    kind;
    int    idx;
    int    exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, tick, key_valid;
  logic [7:0]  gen_ch, key_ch;
  logic [2:0]  gen_speed, rd_idx;
  logic [8:0]  gen_x;
  logic [9:0]  gen_y;
  logic        rd_active, game_over;
  logic [7:0]  rd_ch, miss;
  logic [8:0]  rd_x;
  logic [9:0]  rd_y;
  logic [15:0] score;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_busy = 1'b0;

  falling_char_tracker dut (
    .clk(clk), .rst(rst), .tick(tick),
    .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
    .key_valid(key_valid), .key_ch(key_ch), .rd_idx(rd_idx),
    .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .score(score), .miss(miss), .game_over(game_over)
  );

  always #50 clk = ~clk;

  // Monitor: pops each expectation, points rd_idx at the slot, samples 1 time unit later.
  initial begin
    exp_t e;
    int   actual;
    rd_idx = 3'd0;
    forever begin
      wait (sb.size() > 0);
      mon_busy = 1'b1;
      e = sb.pop_front();
      rd_idx = e.idx[2:0];
      #1;
      case (e.kind)
        K_ACT:   actual = {31'd0, rd_active};
        K_CH:    actual = {24'd0, rd_ch};
        K_X:     actual = {23'd0, rd_x};
        K_Y:     actual = {22'd0, rd_y};
        K_SCORE: actual = {16'd0, score};
        K_MISS:  actual = {24'd0, miss};
        default: actual = {31'd0, game_over};
      endcase
      checks++;
      if (actual != e.exp) begin
        failures++;
        $display("[TB] FAIL %s: got %0d expected %0d", e.name, actual, e.exp);
      end
      mon_busy = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int kind, input int idx, input int exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic waitChecks();
    int n;
    for (n = 0; n < 2000; n++) begin
      if (sb.size() == 0 && !mon_busy) break;
      #1;
    end
    if (n >= 2000) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input bit t, input bit k, input logic [7:0] kc);
    @(negedge clk);
    tick      = t;
    key_valid = k;
    key_ch    = kc;
    @(posedge clk);
    #1;
    tick      = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic setGen(input logic [7:0] c, input logic [2:0] s, input logic [8:0] x,
                        input logic [9:0] y);
    gen_ch    = c;
    gen_speed = s;
    gen_x     = x;
    gen_y     = y;
  endtask

  // Tick and key are held high during reset to show that reset wins.
  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    tick      = 1'b1;
    key_valid = 1'b1;
    key_ch    = 8'h41;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    tick      = 1'b0;
    key_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; key_valid = 1'b0; key_ch = 8'h00;
    setGen(8'h00, 3'd1, 9'd0, 10'd0);

    doReset();
    checkOutput("rst_score", K_SCORE, 0, 0);
    checkOutput("rst_miss", K_MISS, 0, 0);
    checkOutput("rst_game_over", K_GO, 0, 0);
    checkOutput("rst_act0", K_ACT, 0, 0);
    checkOutput("rst_act7", K_ACT, 7, 0);
    waitChecks();

    // Hit priority: slots 0..3 = 'A','b','C','b'.
    setGen(8'h41, 3'd1, 9'd0, 10'd1); runTicks(60);
    setGen(8'h62, 3'd1, 9'd0, 10'd2); runTicks(60);
    setGen(8'h43, 3'd1, 9'd0, 10'd3); runTicks(60);
    setGen(8'h62, 3'd1, 9'd0, 10'd4); runTicks(60);
    checkOutput("fill_act1", K_ACT, 1, 1);
    checkOutput("fill_ch3", K_CH, 3, 8'h62);
    checkOutput("fill_x0", K_X, 0, 180);
    checkOutput("fill_x3", K_X, 3, 0);
    waitChecks();
    applyStimulus(1'b0, 1'b1, 8'h62);
    checkOutput("hit_act1", K_ACT, 1, 0);
    checkOutput("hit_act3", K_ACT, 3, 1);
    checkOutput("hit_score", K_SCORE, 0, 1);
    waitChecks();
    applyStimulus(1'b0, 1'b1, 8'h7A);
    checkOutput("nomatch_score", K_SCORE, 0, 1);
    checkOutput("nomatch_act0", K_ACT, 0, 1);
    checkOutput("nomatch_act3", K_ACT, 3, 1);
    waitChecks();

    // Slot 0 hit on the spawn tick: spawn goes to slot 1, not the just-freed slot 0.
    setGen(8'h44, 3'd1, 9'd0, 10'd7);
    runTicks(59);
    applyStimulus(1'b1, 1'b1, 8'h41);
    checkOutput("reuse_act0", K_ACT, 0, 0);
    checkOutput("reuse_act1", K_ACT, 1, 1);
    checkOutput("reuse_ch1", K_CH, 1, 8'h44);
    checkOutput("reuse_x1", K_X, 1, 0);
    checkOutput("reuse_x2", K_X, 2, 120);
    checkOutput("reuse_score", K_SCORE, 0, 2);
    waitChecks();

    // Miss at the bottom.
    doReset();
    setGen(8'h71, 3'd3, 9'd468, 10'd5); runTicks(60);
    checkOutput("pre_miss_x", K_X, 0, 468);
    checkOutput("pre_miss_act", K_ACT, 0, 1);
    waitChecks();
    runTicks(1);
    checkOutput("miss_act", K_ACT, 0, 0);
    checkOutput("miss_count", K_MISS, 0, 1);
    checkOutput("miss_score", K_SCORE, 0, 0);
    waitChecks();

    // Hit and miss on the same tick: hit wins; then a plain miss landing exactly on X_LIMIT.
    doReset();
    setGen(8'h63, 3'd1, 9'd469, 10'd2); runTicks(60);
    applyStimulus(1'b1, 1'b1, 8'h63);
    checkOutput("simul_act", K_ACT, 0, 0);
    checkOutput("simul_score", K_SCORE, 0, 1);
    checkOutput("simul_miss", K_MISS, 0, 0);
    waitChecks();
    runTicks(59);
    checkOutput("edge_x", K_X, 0, 469);
    waitChecks();
    runTicks(1);
    checkOutput("edge_act", K_ACT, 0, 0);
    checkOutput("edge_miss", K_MISS, 0, 1);
    checkOutput("edge_score", K_SCORE, 0, 1);
    waitChecks();

    // Full table: slot 0 parked at speed 0 so it survives until the ninth spawn attempt.
    doReset();
    setGen(8'h30, 3'd0, 9'd0, 10'd0); runTicks(60);
    for (int k = 1; k < 8; k++) begin
      setGen(8'h30 + 8'(k), 3'd1, 9'd0, 10'(k));
      runTicks(60);
    end
    setGen(8'h5A, 3'd2, 9'd5, 10'd9); runTicks(60);
    checkOutput("full_act0", K_ACT, 0, 1);
    checkOutput("full_ch0", K_CH, 0, 8'h30);
    checkOutput("full_x0", K_X, 0, 0);
    checkOutput("full_act3", K_ACT, 3, 1);
    checkOutput("full_ch7", K_CH, 7, 8'h37);
    checkOutput("full_x7", K_X, 7, 60);
    checkOutput("full_x1", K_X, 1, 420);
    checkOutput("full_y5", K_Y, 5, 5);
    checkOutput("full_miss", K_MISS, 0, 0);
    waitChecks();

    // Game over after ten misses, with slot 0 as a frozen witness.
    doReset();
    setGen(8'h6D, 3'd4, 9'd469, 10'd1); runTicks(540);
    checkOutput("go_miss8", K_MISS, 0, 8);
    waitChecks();
    setGen(8'h6E, 3'd1, 9'd0, 10'd3); runTicks(60);
    setGen(8'h6D, 3'd4, 9'd469, 10'd1); runTicks(60);
    checkOutput("go_miss9", K_MISS, 0, 9);
    checkOutput("go_slot1_spawn", K_ACT, 1, 1);
    waitChecks();
    runTicks(1);
    checkOutput("go_miss10", K_MISS, 0, 10);
    checkOutput("go_not_yet", K_GO, 0, 0);
    checkOutput("go_x0_before", K_X, 0, 61);
    waitChecks();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("go_set", K_GO, 0, 1);
    waitChecks();
    runTicks(70);
    applyStimulus(1'b1, 1'b1, 8'h6E);
    applyStimulus(1'b0, 1'b1, 8'h6E);
    checkOutput("frz_act0", K_ACT, 0, 1);
    checkOutput("frz_x0", K_X, 0, 61);
    checkOutput("frz_ch0", K_CH, 0, 8'h6E);
    checkOutput("frz_act1", K_ACT, 1, 0);
    checkOutput("frz_score", K_SCORE, 0, 0);
    checkOutput("frz_miss", K_MISS, 0, 10);
    checkOutput("frz_go", K_GO, 0, 1);
    waitChecks();

    // Reset mid-game, then the first spawn lands on exactly the 60th tick.
    doReset();
    checkOutput("r2_act0", K_ACT, 0, 0);
    checkOutput("r2_x0", K_X, 0, 0);
    checkOutput("r2_ch0", K_CH, 0, 0);
    checkOutput("r2_miss", K_MISS, 0, 0);
    checkOutput("r2_go", K_GO, 0, 0);
    waitChecks();
    setGen(8'h61, 3'd2, 9'd0, 10'd90);
    runTicks(59);
    checkOutput("spawn59_act0", K_ACT, 0, 0);
    waitChecks();
    runTicks(1);
    checkOutput("spawn_act0", K_ACT, 0, 1);
    checkOutput("spawn_ch0", K_CH, 0, 8'h61);
    checkOutput("spawn_x0", K_X, 0, 0);
    checkOutput("spawn_y0", K_Y, 0, 90);
    checkOutput("spawn_act1", K_ACT, 1, 0);
    waitChecks();
    runTicks(1);
    checkOutput("move_x0", K_X, 0, 2);
    waitChecks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/falling_char_tracker.md
FALLING_CHAR_TRACKER -- requirements
Module: falling_char_tracker

Interface
REQ-001 SHALL have parameter SLOTS, default 8, number of on-screen character slots (rd_idx width fixed at 3 bits).
REQ-002 SHALL have parameter X_LIMIT, default 9'd470, row at or beyond which a character counts as missed.
REQ-003 SHALL have parameter SPAWN_PERIOD, default 60, ticks between spawn attempts.
REQ-004 SHALL have parameter MISS_MAX, default 10, miss count that ends the game.
REQ-005 SHALL have ports as listed, one per line:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle frame strobe.
- gen_ch  in  8  spawned character code from the generator.
- gen_speed  in  3  rows per tick, valid range 1..4.
- gen_x  in  9  start row.
- gen_y  in  10  column.
- key_valid  in  1  one-cycle pulse, key_ch valid.
- key_ch  in  8  typed character code.
- rd_idx  in  3  slot select for readout.
- rd_active  out  1  selected slot occupied.
- rd_ch  out  8  selected slot character.
- rd_x  out  9  selected slot row.
- rd_y  out  10  selected slot column.
- score  out  16  matched-character count.
- miss  out  8  missed-character count.
- game_over  out  1  game ended flag.

Function
REQ-006 SHALL hold per slot: active bit, ch, speed, x, y registers.
REQ-007 SHALL keep a spawn counter that increments on each tick while not game_over and wraps to 0 after reaching SPAWN_PERIOD-1.
REQ-008 SHALL attempt a spawn on the tick where the counter wraps: gen_* captured into the lowest-index inactive slot, slot set active.
REQ-009 SHALL drop the spawn silently when all slots are active; counter still wraps.
REQ-010 SHALL, on each tick, add the slot's speed to x for every slot active at the start of the cycle; a slot spawned this cycle SHALL not move in that cycle.
REQ-011 SHALL compute x + speed at 10 bits; if result >= X_LIMIT, slot cleared inactive and counted as missed; x otherwise takes the 9-bit result.
REQ-012 SHALL add all misses occurring in one cycle to miss in that cycle, saturating at 255.
REQ-013 SHALL, on key_valid, clear the lowest-index active slot whose ch equals key_ch and increment score, saturating at 65535; no match changes nothing.
REQ-014 SHALL evaluate key match against state at cycle start; a matched slot that would also miss on the same tick SHALL count as a hit only (no miss, no move).
REQ-015 SHALL not reuse a slot freed (hit or miss) in the same cycle for a spawn; freed slot eligible next cycle onward.
REQ-016 SHALL set game_over, registered, in the cycle after miss becomes >= MISS_MAX; while game_over, no spawn, movement, counter advance, or key action occurs; slot contents freeze.
REQ-017 SHALL drive rd_* combinationally from slot rd_idx; rd_idx >= SLOTS returns all zeros.
REQ-018 SHALL register score, miss, game_over as outputs; updates visible the cycle after the causing event.

Reset
REQ-019 SHALL, while rst high at a clk edge, clear all active bits, slot fields, spawn counter, score, miss, game_over to 0; rst overrides tick and key_valid in the same cycle.
REQ-020 SHALL treat reset mid-game identically; first spawn after reset occurs on the SPAWN_PERIOD-th tick.

Verification
REQ-021 Spawn: rst, then 60 ticks with gen_ch=8'h61, speed=2, x=0, y=90 -> slot 0 active, ch=8'h61, x=0, y=90; next tick x=2.
REQ-022 Miss: slot at x=468, speed=3, tick -> slot inactive, miss=1 next cycle, score unchanged.
REQ-023 Hit priority: slots 1 and 3 both ch=8'h62, key_valid key_ch=8'h62 -> slot 1 cleared, slot 3 kept, score=1; key 8'h7A -> no change.
REQ-024 Simultaneous: slot at x=469 ch=8'h63, tick and key 8'h63 same cycle -> score +1, miss unchanged.
REQ-025 Full/game over: fill 8 slots, spawn tick -> no change; force 10 misses -> game_over=1, further ticks and keys leave all state frozen until rst clears everything to 0.
